// File: rtl/tx_beam_ch.sv
// tx_beam_ch: per-channel transmit beamforming pulser with a per-beam focusing delay LUT.
// After the LUT delay it emits an n-period bipolar burst on tx_p/tx_n; tx_en marks the transmit window.
module tx_beam_ch #(
    parameter int ADDR_WD = 8,
    parameter int DLY_WD  = 12,
    parameter int HP_WD   = 6,
    parameter int NCYC_WD = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               lut_we,
    input  logic [ADDR_WD-1:0] lut_addr,
    input  logic [DLY_WD:0]    lut_din,
    input  logic               fire,
    input  logic [ADDR_WD-1:0] beam_addr,
    input  logic [HP_WD-1:0]   half_per,
    input  logic [NCYC_WD-1:0] n_cycles,
    input  logic               abort,
    output logic               tx_p,
    output logic               tx_n,
    output logic               tx_en,
    output logic               tx_done,
    output logic               busy
);
    typedef enum logic [2:0] {IDLE, RD, DLY, PLS_P, PLS_N, DONE} state_t;

    state_t             state_q, state_d;
    logic [DLY_WD:0]    lut_mem [2**ADDR_WD];
    logic [DLY_WD:0]    rd_q;
    logic [DLY_WD-1:0]  dly_q, dly_d;
    logic [HP_WD-1:0]   hp_q, hp_d, hcnt_q, hcnt_d;
    logic [NCYC_WD-1:0] ncyc_q, ncyc_d;
    logic               tx_p_d, tx_n_d, tx_en_d, tx_done_d, busy_d;

    // The LUT is read with the fire-cycle beam address, so its data is ready while in RD.
    always_ff @(posedge clk) begin
        if (lut_we)
            lut_mem[lut_addr] <= lut_din;
        rd_q <= lut_mem[beam_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dly_q   <= '0;
            hp_q    <= '0;
            hcnt_q  <= '0;
            ncyc_q  <= '0;
            tx_p    <= 1'b0;
            tx_n    <= 1'b0;
            tx_en   <= 1'b0;
            tx_done <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
            hp_q    <= hp_d;
            hcnt_q  <= hcnt_d;
            ncyc_q  <= ncyc_d;
            tx_p    <= tx_p_d;
            tx_n    <= tx_n_d;
            tx_en   <= tx_en_d;
            tx_done <= tx_done_d;
            busy    <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        hp_d    = hp_q;
        hcnt_d  = hcnt_q;
        ncyc_d  = ncyc_q;
        case (state_q)
            IDLE: if (fire) begin
                state_d = RD;
                hp_d    = (half_per == '0) ? HP_WD'(1) : half_per;
                ncyc_d  = n_cycles;
            end
            RD: begin
                state_d = (!rd_q[DLY_WD] || ncyc_q == '0) ? DONE : DLY;
                dly_d   = rd_q[DLY_WD-1:0];
            end
            DLY: begin
                state_d = (dly_q == '0) ? PLS_P : DLY;
                dly_d   = dly_q - 1'b1;
                hcnt_d  = hp_q - 1'b1;
            end
            PLS_P: begin
                state_d = (hcnt_q == '0) ? PLS_N : PLS_P;
                hcnt_d  = (hcnt_q == '0) ? hp_q - 1'b1 : hcnt_q - 1'b1;
            end
            PLS_N: begin
                state_d = (hcnt_q != '0) ? PLS_N : (ncyc_q == NCYC_WD'(1)) ? DONE : PLS_P;
                hcnt_d  = (hcnt_q == '0) ? hp_q - 1'b1 : hcnt_q - 1'b1;
                ncyc_d  = (hcnt_q == '0) ? ncyc_q - 1'b1 : ncyc_q;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort)
            state_d = IDLE;
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_comb begin
        tx_p_d    = state_d == PLS_P;
        tx_n_d    = state_d == PLS_N;
        tx_en_d   = state_d inside {RD, DLY, PLS_P, PLS_N};
        tx_done_d = state_d == DONE;
        busy_d    = state_d != IDLE;
    end
endmodule
